// File: rtl/hamming_rx_sequencer.sv
// Sequences a serial (7,4) Hamming decoder: start detect, 7-bit enable gate, nibble pair -> byte.
// Latency: byte_valid rises 1 cycle after the high-nibble dec_valid; HAMMING_RX_FRAME_TIMEOUT_EN adds an inter-nibble gap timeout.
// Backpressure: byte_valid/byte_ready; a byte completing while the output is still full is dropped with an overrun pulse.
module hamming_rx_sequencer #(
    parameter bit IDLE_LEVEL  = 1'b1,
    parameter int DEC_TIMEOUT = 8,
    parameter int GAP_MAX     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       serial_in,
    output logic       dec_ena,
    output logic       dec_bit,
    input  logic       dec_valid,
    input  logic [3:0] dec_nibble,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       dec_err,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DEC} state_t;

    localparam logic [7:0] DEC_TO = 8'(DEC_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] timer_q, timer_d;
    logic       nib_idx_q, nib_idx_d;
    logic [3:0] low_nib_q, low_nib_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_vld_q, byte_vld_d;
    logic       dec_err_q, dec_err_d;
    logic       overrun_q, overrun_d;
    logic       start_bit;

`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

    assign start_bit = (serial_in != IDLE_LEVEL);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        nib_idx_d  = nib_idx_q;
        low_nib_d  = low_nib_q;
        byte_d     = byte_q;
        byte_vld_d = byte_vld_q;
        dec_err_d  = 1'b0;
        overrun_d  = 1'b0;
        dec_ena    = 1'b0;
`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        // The downstream handshake completes even while ena is low.
        if (byte_vld_q && byte_ready) begin
            byte_vld_d = 1'b0;
        end

        if (ena) begin
`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
            gap_cnt_d = '0;
`endif
            case (state_q)
                IDLE: begin
                    if (start_bit) begin
                        state_d   = SHIFT;
                        bit_cnt_d = 3'd0;
                    end
`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
                    else if (nib_idx_q) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            nib_idx_d = 1'b0;
                            dec_err_d = 1'b1;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                SHIFT: begin
                    dec_ena = 1'b1;
                    if (bit_cnt_q == 3'd6) begin
                        state_d = WAIT_DEC;
                        timer_d = 8'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                WAIT_DEC: begin
                    timer_d = timer_q + 8'd1;
                    if (dec_valid) begin
                        state_d = IDLE;
                        if (!nib_idx_q) begin
                            low_nib_d = dec_nibble;
                            nib_idx_d = 1'b1;
                        end else begin
                            nib_idx_d = 1'b0;
                            // A same-cycle accept frees the output register.
                            if (!byte_vld_q || byte_ready) begin
                                byte_d     = {dec_nibble, low_nib_q};
                                byte_vld_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else if (timer_q == DEC_TO) begin
                        state_d   = IDLE;
                        nib_idx_d = 1'b0;
                        dec_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            timer_q    <= 8'd0;
            nib_idx_q  <= 1'b0;
            low_nib_q  <= 4'd0;
            byte_q     <= 8'd0;
            byte_vld_q <= 1'b0;
            dec_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            nib_idx_q  <= nib_idx_d;
            low_nib_q  <= low_nib_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            dec_err_q  <= dec_err_d;
            overrun_q  <= overrun_d;
`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign dec_bit    = serial_in;
    assign byte_out   = byte_q;
    assign byte_valid = byte_vld_q;
    assign busy       = (state_q != IDLE) || nib_idx_q;
    assign dec_err    = dec_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// Directed bench for hamming_rx_sequencer; the bench itself plays the decoder and the downstream FIFO.
module tb_hamming_rx_sequencer;

    localparam int DEC_TIMEOUT = 8;
    localparam int GAP_MAX     = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       serial_in = 1'b1;
    logic       dec_valid = 1'b0;
    logic [3:0] dec_nibble = 4'h0;
    logic       byte_ready = 1'b0;
    logic       dec_ena, dec_bit, byte_valid, busy, dec_err, overrun;
    logic [7:0] byte_out;

    int n_checks = 0;
    int n_err = 0;
    int err_pulses = 0;
    int ovr_pulses = 0;
    int e0, o0;

    hamming_rx_sequencer #(
        .IDLE_LEVEL (1'b1),
        .DEC_TIMEOUT(DEC_TIMEOUT),
        .GAP_MAX    (GAP_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .serial_in (serial_in),
        .dec_ena   (dec_ena),
        .dec_bit   (dec_bit),
        .dec_valid (dec_valid),
        .dec_nibble(dec_nibble),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .busy      (busy),
        .dec_err   (dec_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (dec_err === 1'b1) err_pulses++;
        if (overrun === 1'b1) ovr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Start bit + 7 codeword bits, then optionally return a nibble as the decoder.
    task automatic send_nib(input logic [3:0] nib, input bit give, input bit rdy, input int pause_at);
        int hi_cnt;
        hi_cnt = 0;
        @(negedge clk);
        serial_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == pause_at) begin
                ena = 1'b0;
                #1;
                check("freeze_dec_ena", dec_ena, 0);
                check("freeze_busy", busy, 1);
                repeat (4) begin
                    @(negedge clk);
                    check("freeze_dec_ena", dec_ena, 0);
                end
                @(negedge clk);
                ena = 1'b1;
                #1;
            end
            hi_cnt += int'(dec_ena);
            serial_in = nib[i % 4] ^ (i > 3);
        end
        @(negedge clk);
        hi_cnt += int'(dec_ena);
        serial_in = 1'b1;
        check("dec_ena_cycles", hi_cnt, 7);
        if (give) begin
            dec_valid  = 1'b1;
            dec_nibble = nib;
            byte_ready = rdy;
            @(negedge clk);
            dec_valid  = 1'b0;
            byte_ready = 1'b0;
        end
    endtask

    task automatic drain(input logic [7:0] exp);
        check("byte_valid", byte_valid, 1);
        check("byte_out", byte_out, exp);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        check("byte_valid_clr", byte_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_dec_ena", dec_ena, 0);
        check("rst_dec_bit", dec_bit, 1);
        check("rst_byte_out", byte_out, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dec_err", dec_err, 0);
        check("rst_overrun", overrun, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, low nibble first
        send_nib(4'h5, 1, 0, -1);
        check("low_held_busy", busy, 1);
        check("low_no_byte", byte_valid, 0);
        send_nib(4'hA, 1, 0, -1);
        drain(8'hA5);

        // Stray dec_valid in IDLE
        @(negedge clk);
        dec_valid = 1'b1;
        dec_nibble = 4'hF;
        @(negedge clk);
        dec_valid = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_byte_valid", byte_valid, 0);

        // Backpressure: second byte dropped
        send_nib(4'h2, 1, 0, -1);
        send_nib(4'h1, 1, 0, -1);
        check("bp_first_byte", byte_out, 8'h12);
        o0 = ovr_pulses;
        send_nib(4'h4, 1, 0, -1);
        send_nib(4'h3, 1, 0, -1);
        check("bp_overrun", overrun, 1);
        check("bp_byte_kept", byte_out, 8'h12);
        check("bp_valid_kept", byte_valid, 1);
        @(negedge clk);
        check("bp_overrun_pulses", ovr_pulses - o0, 1);
        check("bp_overrun_end", overrun, 0);
        // Same-cycle accept makes room
        send_nib(4'h4, 1, 0, -1);
        send_nib(4'h3, 1, 1, -1);
        check("acc_no_overrun", overrun, 0);
        drain(8'h34);
        check("acc_overrun_pulses", ovr_pulses - o0, 1);

        // Decoder timeout on the high nibble
        send_nib(4'h7, 1, 0, -1);
        send_nib(4'h0, 0, 0, -1);
        e0 = err_pulses;
        repeat (DEC_TIMEOUT - 1) @(negedge clk);
        check("to_no_early_err", err_pulses - e0, 0);
        repeat (6) @(negedge clk);
        check("to_err_pulses", err_pulses - e0, 1);
        check("to_busy_clear", busy, 0);
        send_nib(4'h8, 1, 0, -1);
        send_nib(4'h9, 1, 0, -1);
        drain(8'h98);

        // ena low for 5 cycles mid-SHIFT
        send_nib(4'h6, 1, 0, 3);
        send_nib(4'hB, 1, 0, -1);
        drain(8'hB6);

        // Reset mid-frame drops the held nibble
        send_nib(4'h5, 1, 0, -1);
        @(negedge clk);
        serial_in = 1'b0;
        #1;
        check("dec_bit_pass", dec_bit, 0);
        @(negedge clk);
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_dec_ena", dec_ena, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_nib(4'h1, 1, 0, -1);
        send_nib(4'h2, 1, 0, -1);
        drain(8'h21);

        // Long gap between nibbles
        send_nib(4'h5, 1, 0, -1);
        e0 = err_pulses;
        repeat (GAP_MAX + 5) @(negedge clk);
`ifdef HAMMING_RX_FRAME_TIMEOUT_EN
        check("gap_err_pulses", err_pulses - e0, 1);
        check("gap_busy_clear", busy, 0);
        send_nib(4'h3, 1, 0, -1);
        send_nib(4'hC, 1, 0, -1);
        drain(8'hC3);
`else
        check("gap_no_err", err_pulses - e0, 0);
        check("gap_busy_held", busy, 1);
        send_nib(4'hA, 1, 0, -1);
        drain(8'hA5);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
